// File: rtl/vid_pkg.sv
// Shared constants, state encoding and FIFO entry type for the frame grabber.
package vid_pkg;

    localparam logic [17:0] VID_ORG = 18'h37FC0;
    localparam int          HPIX    = 1024;
    localparam int          VLINES  = 768;
    localparam int          WPL     = HPIX / 32;

    localparam logic [10:0] HPIX_X   = 11'(HPIX);
    localparam logic [9:0]  VLINES_Y = 10'(VLINES);
    localparam logic [9:0]  Y_LAST   = 10'(VLINES - 1);
    localparam logic [4:0]  WI_LAST  = 5'(WPL - 1);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} vid_state_t;

    typedef struct packed {
        logic [17:0] adr;
        logic [31:0] data;
    } wentry_t;

    // Display map: lines are stored bottom-up, so the line index is inverted.
    function automatic logic [17:0] word_adr(input logic [9:0] y, input logic [4:0] wi);
        return VID_ORG + {3'b0, ~y, wi};
    endfunction

    localparam logic [17:0] LAST_ADR = word_adr(Y_LAST, WI_LAST);

endpackage

// File: rtl/vid_wfifo.sv
// Two-entry write FIFO between the pixel packer and the SRAM port.
module vid_wfifo import vid_pkg::*; (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wentry_t din,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wentry_t head
);

    wentry_t    mem [2];
    logic       wp, rp;
    logic [1:0] cnt;
    logic       do_push, do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign head    = mem[rp];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full is still taken.
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; reset flushes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (do_pop) rp <= ~rp;
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/vid_capture.sv
// Monochrome frame grabber: packs 32 pixels per word and queues SRAM writes.
module vid_capture import vid_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        inv,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        pix_valid,
    input  logic        pix,
    output logic        wreq,
    output logic [17:0] wadr,
    output logic [31:0] wdata,
    input  logic        wack,
    output logic        busy,
    output logic        frame_done,
    output logic        ovf
);

    vid_state_t  state, state_nx;
    logic        vs_r, vs_p, hs_r, hs_p;
    logic        vs_edge, hs_edge;
    logic [10:0] x, x_nx;
    logic [9:0]  y, y_nx;
    logic        started, started_nx;
    logic [31:0] sh, sh_nx, word;
    logic        cap, push, push_last, pop, drop, pop_last, fd_set;
    logic        full, empty;
    wentry_t     din, head;

    assign vs_edge  = vs_r && !vs_p;
    assign hs_edge  = hs_r && !hs_p;
    assign pop      = wack && !empty;
    assign drop     = push && full && !pop;
    assign pop_last = pop && (head.adr == LAST_ADR);
    assign fd_set   = pop_last || (drop && push_last);

    assign wreq  = !empty;
    assign wadr  = head.adr;
    assign wdata = head.data;
    assign busy  = (state == ACTIVE);

    // Register the sync inputs once and keep the previous value for edge detect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vs_r <= 1'b0; vs_p <= 1'b0;
            hs_r <= 1'b0; hs_p <= 1'b0;
        end else begin
            vs_r <= vsync_in; vs_p <= vs_r;
            hs_r <= hsync_in; hs_p <= hs_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state: en=0 always wins, a frame ends when its last word retires.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = ARMED;
            ARMED:   if (!en) state_nx = IDLE; else if (vs_edge) state_nx = ACTIVE;
            ACTIVE:  if (!en) state_nx = IDLE; else if (fd_set) state_nx = ARMED;
            default: state_nx = IDLE;
        endcase
    end

    // Sync handling first, then the pixel lands on the updated position.
    always_comb begin
        x_nx       = x;
        y_nx       = y;
        sh_nx      = sh;
        started_nx = started;
        word       = sh;
        push       = 1'b0;
        push_last  = 1'b0;
        din        = '0;
        cap        = en && ((state == ACTIVE) || (state == ARMED && vs_edge));
        if (!cap) begin
            x_nx = '0; y_nx = '0; sh_nx = '0; started_nx = 1'b0;
        end else begin
            if (vs_edge) begin
                x_nx = '0; y_nx = '0; sh_nx = '0; started_nx = 1'b0;
            end else if (hs_edge) begin
                // First hsync of the frame opens line 0 without advancing y.
                if (started && y < VLINES_Y) y_nx = y + 10'd1;
                x_nx = '0; sh_nx = '0; started_nx = 1'b1;
            end
            if (pix_valid && x_nx < HPIX_X && y_nx < VLINES_Y) begin
                word = sh_nx;
                word[x_nx[4:0]] = pix ^ inv;
                if (&x_nx[4:0]) begin
                    push      = 1'b1;
                    din.adr   = word_adr(y_nx, x_nx[9:5]);
                    din.data  = word;
                    push_last = (y_nx == Y_LAST) && (x_nx[9:5] == WI_LAST);
                    sh_nx     = '0;
                end else begin
                    sh_nx = word;
                end
                x_nx = x_nx + 11'd1;
            end
        end
    end

    // Position counters and the partial word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x <= '0; y <= '0; sh <= '0; started <= 1'b0;
        end else begin
            x <= x_nx; y <= y_nx; sh <= sh_nx; started <= started_nx;
        end
    end

    // frame_done pulse and sticky overflow (cleared while disabled).
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            frame_done <= fd_set;
            ovf        <= en ? (ovf || drop) : 1'b0;
        end
    end

    vid_wfifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (wack),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

endmodule

// File: tb/tb_vid_capture.sv
// Self-checking bench for vid_capture: vector table plus model-checked random lines.
module tb_vid_capture;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, inv = 1'b0;
    logic        vsync_in = 1'b0, hsync_in = 1'b0, pix_valid = 1'b0, pix = 1'b0, wack = 1'b0;
    logic        wreq, busy, frame_done, ovf;
    logic [17:0] wadr;
    logic [31:0] wdata;

    int checks = 0, errors = 0;
    int nwr = 0, fd_cnt = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic [17:0] adr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          nhs;
        bit          iv;
        logic [31:0] pat;
        logic [17:0] adr;
        logic [31:0] data;
    } vec_t;

    wr_t  exp_q[$];
    bit   px_q[$];
    wr_t  mon_e;
    vec_t tbl[5];

    always #5 clk = ~clk;

    vid_capture dut (
        .clk(clk), .rst(rst), .en(en), .inv(inv),
        .vsync_in(vsync_in), .hsync_in(hsync_in), .pix_valid(pix_valid), .pix(pix),
        .wreq(wreq), .wadr(wadr), .wdata(wdata), .wack(wack),
        .busy(busy), .frame_done(frame_done), .ovf(ovf)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic vs_pulse();
        vsync_in = 1'b1; tick(); vsync_in = 1'b0; tick();
    endtask

    task automatic hs_pulse();
        hsync_in = 1'b1; tick(); hsync_in = 1'b0; tick();
    endtask

    task automatic gen_px(input int n);
        px_q.delete();
        for (int i = 0; i < n; i++) px_q.push_back(1'($urandom));
    endtask

    task automatic drive_px(input bit gaps);
        foreach (px_q[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0; tick();
            end
            pix_valid = 1'b1; pix = px_q[i]; tick();
        end
        pix_valid = 1'b0;
    endtask

    // Reference address map: line y lives (1023-y) lines above ORG, modulo 2^18.
    function automatic logic [17:0] m_adr(input int y, input int w);
        int a;
        a = 'h37FC0 + (1023 - y) * 32 + w;
        return 18'(a % 262144);
    endfunction

    function automatic logic [31:0] m_word(input int w, input bit iv);
        logic [31:0] d;
        for (int k = 0; k < 32; k++) d[k] = px_q[w * 32 + k] ^ iv;
        return d;
    endfunction

    // Only complete words inside the 1024-pixel window are written.
    task automatic expect_line(input int y, input bit iv);
        int  n;
        wr_t e;
        n = (px_q.size() < 1024) ? px_q.size() : 1024;
        for (int w = 0; w < n / 32; w++) begin
            e.adr  = m_adr(y, w);
            e.data = m_word(w, iv);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Write monitor: every accepted write is compared with the model queue.
    always @(negedge clk) begin
        if (mon_en && wreq && wack) begin
            if (exp_q.size() == 0) chk("unexpected_write", 64'(wadr), 64'h3_FFFFF);
            else begin
                mon_e = exp_q.pop_front();
                chk("mon_wadr", 64'(wadr), 64'(mon_e.adr));
                chk("mon_wdata", 64'(wdata), 64'(mon_e.data));
            end
            nwr++;
        end
        if (frame_done) fd_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr0, fd0;
        bit iv;

        tbl[0] = '{nhs: 1, iv: 1'b0, pat: 32'h55555555, adr: 18'h3FFA0, data: 32'h55555555};
        tbl[1] = '{nhs: 3, iv: 1'b1, pat: 32'hFFFFFFFF, adr: 18'h3FF60, data: 32'h00000000};
        tbl[2] = '{nhs: 2, iv: 1'b0, pat: 32'h0000FFFF, adr: 18'h3FF80, data: 32'h0000FFFF};
        tbl[3] = '{nhs: 1, iv: 1'b1, pat: 32'h12345678, adr: 18'h3FFA0, data: 32'hEDCBA987};
        tbl[4] = '{nhs: 5, iv: 1'b0, pat: 32'hA5A5A5A5, adr: 18'h3FF20, data: 32'hA5A5A5A5};

        // Reset state
        tick(); tick(); rst = 1'b1;
        chk("rst_wreq", 64'(wreq), 64'd0);
        chk("rst_wadr", 64'(wadr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        en = 1'b1; tick();
        chk("armed_busy", 64'(busy), 64'd0);
        vs_pulse();
        chk("active_busy", 64'(busy), 64'd1);

        // Vector table: one word per entry, checked at the exact latency.
        for (int t = 0; t < 5; t++) begin
            vs_pulse();
            repeat (tbl[t].nhs) hs_pulse();
            inv = tbl[t].iv; wack = 1'b0;
            for (int i = 0; i < 32; i++) begin
                if (i == 31) chk("tbl_early_wreq", 64'(wreq), 64'd0);
                pix_valid = 1'b1; pix = tbl[t].pat[i]; tick();
            end
            pix_valid = 1'b0;
            chk("tbl_wreq", 64'(wreq), 64'd1);
            chk("tbl_wadr", 64'(wadr), 64'(tbl[t].adr));
            chk("tbl_wdata", 64'(wdata), 64'(tbl[t].data));
            wack = 1'b1; tick(); wack = 1'b0;
            chk("tbl_popped", 64'(wreq), 64'd0);
        end

        // Backpressure: two words held, third dropped, ovf sticky until en=0.
        inv = 1'b0; vs_pulse(); hs_pulse();
        gen_px(96); drive_px(1'b0);
        chk("bp_wreq", 64'(wreq), 64'd1);
        chk("bp_ovf", 64'(ovf), 64'd1);
        chk("bp_adr0", 64'(wadr), 64'(m_adr(0, 0)));
        chk("bp_data0", 64'(wdata), 64'(m_word(0, 1'b0)));
        wack = 1'b1; tick();
        chk("bp_adr1", 64'(wadr), 64'(m_adr(0, 1)));
        chk("bp_data1", 64'(wdata), 64'(m_word(1, 1'b0)));
        tick(); wack = 1'b0;
        chk("bp_empty", 64'(wreq), 64'd0);
        chk("bp_ovf_hold", 64'(ovf), 64'd1);
        en = 1'b0; tick();
        chk("bp_ovf_clr", 64'(ovf), 64'd0);
        chk("bp_idle_busy", 64'(busy), 64'd0);
        en = 1'b1; tick();

        // Short line then overrun line, random pixels with gaps.
        wack = 1'b1; mon_en = 1'b1; nwr0 = nwr;
        vs_pulse(); hs_pulse();
        iv = 1'($urandom); inv = iv;
        gen_px(40); expect_line(0, iv); drive_px(1'b1);
        hs_pulse();
        iv = 1'($urandom); inv = iv;
        gen_px(1100); expect_line(1, iv); drive_px(1'b1);
        drain();
        chk("short_nwr", 64'(nwr - nwr0), 64'd33);

        // Last line of the frame: walk y to 767, then one full line.
        nwr0 = nwr; fd0 = fd_cnt;
        vs_pulse();
        repeat (768) hs_pulse();
        chk("fd_early", 64'(fd_cnt - fd0), 64'd0);
        iv = 1'($urandom); inv = iv;
        gen_px(1024); expect_line(767, iv); drive_px(1'b1);
        drain(); tick(); tick();
        chk("frame_nwr", 64'(nwr - nwr0), 64'd32);
        chk("frame_done_cnt", 64'(fd_cnt - fd0), 64'd1);
        chk("frame_armed", 64'(busy), 64'd0);

        // Reset mid-frame with a pending request.
        mon_en = 1'b0; wack = 1'b0; inv = 1'b0;
        vs_pulse(); hs_pulse();
        gen_px(32); drive_px(1'b0);
        chk("rmid_pending", 64'(wreq), 64'd1);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("rmid_wreq", 64'(wreq), 64'd0);
        chk("rmid_busy", 64'(busy), 64'd0);
        tick();
        gen_px(64); drive_px(1'b0);
        chk("rmid_no_write", 64'(wreq), 64'd0);
        vs_pulse(); hs_pulse();
        gen_px(32); drive_px(1'b0);
        chk("rmid_resume_wreq", 64'(wreq), 64'd1);
        chk("rmid_resume_adr", 64'(wadr), 64'(m_adr(0, 0)));
        chk("rmid_resume_data", 64'(wdata), 64'(m_word(0, 1'b0)));
        wack = 1'b1; tick(); wack = 1'b0;
        chk("rmid_drained", 64'(wreq), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
